// File: rtl/axi_lite_slave_regs.sv
// axi_lite_pkg: shared AXI4-Lite field types and response codes.
//
// axi_lite_slave_regs: AXI4-Lite slave that exposes NUM_REGS 32-bit
// read/write registers. Independent read and write state machines, one
// outstanding transaction per direction, byte-strobe writes, and SLVERR
// for any address beyond the register file.
//
// Ports
//   aclk, aresetn          clock (rising edge), async active-low reset
//   araddr/arvalid/arready read address channel
//   rdata/rresp/rvalid/rready read data channel
//   awaddr/awvalid/awready write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready    write response channel
//   regs_o                 live register contents for the fabric
//
// Write FSM
//   state    | meaning
//   W_ACCEPT | collecting AW and W (either order, or together)
//   W_RESP   | write committed, bvalid held until bready
//
// Read FSM
//   state    | meaning
//   R_ACCEPT | arready high, waiting for AR
//   R_DATA   | rvalid high, rdata/rresp held until rready

package axi_lite_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [1:0]  resp_t;
    typedef logic [3:0]  strb_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
endpackage

module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,

    input  addr_t                    araddr,
    input  logic                     arvalid,
    output logic                     arready,

    output data_t                    rdata,
    output resp_t                    rresp,
    output logic                     rvalid,
    input  logic                     rready,

    input  addr_t                    awaddr,
    input  logic                     awvalid,
    output logic                     awready,

    input  data_t                    wdata,
    input  strb_t                    wstrb,
    input  logic                     wvalid,
    output logic                     wready,

    output resp_t                    bresp,
    output logic                     bvalid,
    input  logic                     bready,

    output logic [NUM_REGS-1:0][31:0] regs_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        W_ACCEPT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_ACCEPT,
        R_DATA
    } r_state_t;

    // In range exactly when every bit above the word index is zero.
    function automatic logic addr_in_range(input addr_t a);
        return (a[31:IDX_W+2] == '0);
    endfunction

    // Byte offset within a word carries no meaning for 32-bit registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    logic [NUM_REGS-1:0][31:0] regs;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t w_state;
    logic     aw_held;
    idx_t     aw_idx_q;
    logic     aw_ok_q;
    logic     w_held;
    data_t    w_data_q;
    strb_t    w_strb_q;

    logic     aw_hs;
    logic     w_hs;
    logic     have_aw;
    logic     have_w;
    idx_t     cur_idx;
    logic     cur_ok;
    data_t    cur_data;
    strb_t    cur_strb;
    logic     commit;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // A channel completing this cycle is used directly so that the commit
    // lands on the same edge as the second handshake.
    always_comb begin
        have_aw  = aw_held || aw_hs;
        have_w   = w_held || w_hs;
        cur_idx  = aw_hs ? awaddr[2 +: IDX_W] : aw_idx_q;
        cur_ok   = aw_hs ? addr_in_range(awaddr) : aw_ok_q;
        cur_data = w_hs ? wdata : w_data_q;
        cur_strb = w_hs ? wstrb : w_strb_q;
        commit   = (w_state == W_ACCEPT) && have_aw && have_w;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state  <= W_ACCEPT;
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
            aw_ok_q  <= 1'b0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            case (w_state)
                W_ACCEPT: begin
                    if (commit) begin
                        w_state <= W_RESP;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= cur_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            aw_idx_q <= awaddr[2 +: IDX_W];
                            aw_ok_q  <= addr_in_range(awaddr);
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                        end
                        awready <= !have_aw;
                        wready  <= !have_w;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_ACCEPT;
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: begin
                    w_state <= W_ACCEPT;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            regs <= '0;
        end else if (commit && cur_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_strb[b]) begin
                    regs[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
                end
            end
        end
    end

    assign regs_o = regs;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t r_state;
    logic     ar_hs;
    idx_t     ar_idx;
    logic     ar_ok;

    assign ar_hs  = arvalid && arready;
    assign ar_idx = araddr[2 +: IDX_W];
    assign ar_ok  = addr_in_range(araddr);

    // regs is sampled before any same-edge commit, so a colliding read
    // returns the old contents.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_ACCEPT;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_ACCEPT: begin
                    if (ar_hs) begin
                        r_state <= R_DATA;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rdata   <= ar_ok ? regs[ar_idx] : '0;
                        rresp   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_state <= R_ACCEPT;
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= R_ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs. Stimulus tasks push expected
// B/R responses into queues; a monitor pops and compares on each
// response handshake.

module tb_axi_lite_slave_regs;
    import axi_lite_pkg::*;

    logic                aclk;
    logic                aresetn;
    addr_t               araddr;
    logic                arvalid;
    logic                arready;
    data_t               rdata;
    resp_t               rresp;
    logic                rvalid;
    logic                rready;
    addr_t               awaddr;
    logic                awvalid;
    logic                awready;
    data_t               wdata;
    strb_t               wstrb;
    logic                wvalid;
    logic                wready;
    resp_t               bresp;
    logic                bvalid;
    logic                bready;
    logic [7:0][31:0]    regs_o;

    axi_lite_slave_regs #(.NUM_REGS(8)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .regs_o  (regs_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic [1:0]  exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] exp_regs[8];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s regs_o[%0d]", tag, i), regs_o[i], exp_regs[i]);
        end
    endtask

    // Return to a point just after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awaddr  = a;
        awvalid = 1'b1;
        @(negedge aclk);
        while (!awready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("aw_accept", {31'b0, awready}, 32'd1);
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        @(negedge aclk);
        while (!wready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("w_accept", {31'b0, wready}, 32'd1);
        @(posedge aclk);
        #1;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        araddr  = a;
        arvalid = 1'b1;
        @(negedge aclk);
        while (!arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("ar_accept", {31'b0, arready}, 32'd1);
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
        exp_b.push_back(resp);
        fork
            send_aw(a);
            send_w(d, s);
        join
        step(2);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        exp_r.push_back({d, resp});
        send_ar(a);
        step(2);
    endtask

    // Response monitor and rdata hold check.
    logic        r_hold_valid;
    logic [31:0] r_hold_data;
    logic [1:0]  r_hold_resp;

    always @(negedge aclk) begin
        if (!aresetn) begin
            r_hold_valid = 1'b0;
        end else begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_b", 32'd1, 32'd0);
                end else begin
                    check("bresp", {30'b0, bresp}, {30'b0, exp_b.pop_front()});
                end
            end
            if (rvalid && r_hold_valid) begin
                check("rdata_hold", rdata, r_hold_data);
                check("rresp_hold", {30'b0, rresp}, {30'b0, r_hold_resp});
            end
            if (rvalid && !rready) begin
                r_hold_valid = 1'b1;
                r_hold_data  = rdata;
                r_hold_resp  = rresp;
            end else begin
                r_hold_valid = 1'b0;
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    check("unexpected_r", 32'd1, 32'd0);
                end else begin
                    r_exp_t e;
                    e = exp_r.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", {30'b0, rresp}, {30'b0, e.resp});
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " arready"}, {31'b0, arready}, 32'd0);
        check({tag, " awready"}, {31'b0, awready}, 32'd0);
        check({tag, " wready"},  {31'b0, wready},  32'd0);
        check({tag, " rvalid"},  {31'b0, rvalid},  32'd0);
        check({tag, " bvalid"},  {31'b0, bvalid},  32'd0);
        check({tag, " rdata"},   rdata,            32'd0);
        check({tag, " rresp"},   {30'b0, rresp},   32'd0);
        check({tag, " bresp"},   {30'b0, bresp},   32'd0);
        check_regs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;

        // Reset state and first assertion of the ready signals.
        step(3);
        @(negedge aclk);
        check_reset_outputs("reset");
        step(0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("arready before first edge", {31'b0, arready}, 32'd0);
        @(negedge aclk);
        check("arready after first edge", {31'b0, arready}, 32'd1);
        check("awready after first edge", {31'b0, awready}, 32'd1);
        check("wready after first edge",  {31'b0, wready},  32'd1);
        step(1);

        // AW and W together to 0x4.
        exp_b.push_back(RESP_OKAY);
        fork
            send_aw(32'h4);
            send_w(32'hDEADBEEF, 4'hF);
        join
        @(negedge aclk);
        check("bvalid after commit", {31'b0, bvalid}, 32'd1);
        step(2);
        exp_regs[1] = 32'hDEADBEEF;
        @(negedge aclk);
        check_regs("full write");
        step(1);

        // W ahead of AW, single byte lane into a populated register.
        do_write(32'h8, 32'h11223344, 4'hF, RESP_OKAY);
        exp_b.push_back(RESP_OKAY);
        send_w(32'h000000AA, 4'h1);
        @(negedge aclk);
        check("wready after W latched", {31'b0, wready}, 32'd0);
        check("awready while W latched", {31'b0, awready}, 32'd1);
        check("no bvalid with W only", {31'b0, bvalid}, 32'd0);
        step(2);
        send_aw(32'h8);
        step(2);
        exp_regs[2] = 32'h112233AA;
        @(negedge aclk);
        check_regs("w first");
        step(1);

        // Read with rready held low for 4 cycles.
        rready = 1'b0;
        exp_r.push_back({32'hDEADBEEF, RESP_OKAY});
        send_ar(32'h4);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("rvalid while stalled", {31'b0, rvalid}, 32'd1);
            check("arready while stalled", {31'b0, arready}, 32'd0);
        end
        step(1);
        rready = 1'b1;
        @(negedge aclk);
        check("arready on rready cycle", {31'b0, arready}, 32'd0);
        @(negedge aclk);
        check("arready after rready", {31'b0, arready}, 32'd1);
        check("rvalid after rready", {31'b0, rvalid}, 32'd0);
        step(1);

        // Out-of-range write and read.
        do_write(32'h20, 32'hCAFEF00D, 4'hF, RESP_SLVERR);
        do_read(32'h20, 32'h0, RESP_SLVERR);
        @(negedge aclk);
        check_regs("out of range");
        step(1);

        // AR and write commit to 0xC on the same edge.
        exp_b.push_back(RESP_OKAY);
        exp_r.push_back({32'h0, RESP_OKAY});
        send_w(32'h12345678, 4'hF);
        step(1);
        fork
            send_aw(32'hC);
            send_ar(32'hC);
        join
        step(2);
        exp_regs[3] = 32'h12345678;
        do_read(32'hC, 32'h12345678, RESP_OKAY);

        // Sparse strobes, ignored low address bits, zero strobe.
        do_write(32'h3, 32'hAABBCCDD, 4'hA, RESP_OKAY);
        exp_regs[0] = 32'hAA00CC00;
        do_write(32'h0, 32'hFFFFFFFF, 4'h0, RESP_OKAY);
        do_read(32'h1, 32'hAA00CC00, RESP_OKAY);
        do_read(32'h1C, 32'h0, RESP_OKAY);
        @(negedge aclk);
        check_regs("strobes");
        step(1);

        // Reset between AW and W discards the latched AW.
        send_aw(32'h10);
        aresetn = 1'b0;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        @(negedge aclk);
        check_reset_outputs("mid reset");
        step(1);
        aresetn = 1'b1;
        step(2);
        send_w(32'h55555555, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("no bvalid after reset", {31'b0, bvalid}, 32'd0);
        end
        check_regs("after aborted write");
        step(1);

        check("b queue drained", exp_b.size(), 32'd0);
        check("r queue drained", exp_r.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 Parameter NUM_REGS, default 8, SHALL set the number of 32-bit registers (power of two, 2..256).
REQ-002 addr_t, data_t, resp_t and strb_t SHALL come from axi_lite_pkg: 32-bit address, 32-bit data, 2-bit response, 4-bit strobe.
REQ-003 aclk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 aresetn  in  1  reset, asynchronous and active-low.
REQ-005 araddr/arvalid  in  addr_t/1; arready  out  1  read address channel.
REQ-006 rdata/rresp/rvalid  out  data_t/resp_t/1; rready  in  1  read data channel.
REQ-007 awaddr/awvalid  in  addr_t/1; awready  out  1  write address channel.
REQ-008 wdata/wstrb/wvalid  in  data_t/strb_t/1; wready  out  1  write data channel.
REQ-009 bresp/bvalid  out  resp_t/1; bready  in  1  write response channel.
REQ-010 regs_o  out  NUM_REGS x 32  current register contents, for fabric use.

Function
REQ-011 Word index SHALL be addr[2 +: log2(NUM_REGS)]; addr[1:0] SHALL be ignored.
REQ-012 Any address >= NUM_REGS*4 SHALL be decoded as out of range.
REQ-013 Write FSM SHALL have two states: W_ACCEPT and W_RESP.
REQ-014 In W_ACCEPT, awready SHALL be 1 while no AW is latched, and wready SHALL be 1 while no W is latched.
REQ-015 AW and W SHALL be accepted independently, in either order or in the same cycle, and latched until both are present.
REQ-016 On the edge where the second of AW/W completes, the write SHALL commit and the FSM SHALL enter W_RESP with bvalid=1.
REQ-017 Commit SHALL update byte lane n of the target register only where wstrb[n]=1; wstrb=0 SHALL leave the register unchanged but return OKAY.
REQ-018 Out-of-range writes SHALL modify no register and return bresp=2'b10 (SLVERR); in-range writes SHALL return 2'b00.
REQ-019 In W_RESP, awready and wready SHALL be 0; bvalid/bresp SHALL hold until bready=1, then the FSM SHALL return to W_ACCEPT on the next edge.
REQ-020 The block SHALL accept at most one outstanding write and one outstanding read.
REQ-021 Read FSM SHALL have two states: R_ACCEPT (arready=1, rvalid=0) and R_DATA (arready=0, rvalid=1).
REQ-022 On the AR handshake edge, rdata/rresp SHALL be registered from pre-edge register values, and the FSM SHALL enter R_DATA.
REQ-023 Read latency SHALL be 1 cycle: rvalid rises the cycle after the AR handshake.
REQ-024 rdata/rresp SHALL be held stable until rready=1, then the FSM SHALL return to R_ACCEPT on the next edge.
REQ-025 Out-of-range reads SHALL return rdata=0, rresp=2'b10.
REQ-026 Read and write channels SHALL operate concurrently.
REQ-027 If a write commit and an AR handshake to the same register fall on the same edge, the read SHALL return the old value.
REQ-028 Outputs SHALL be driven from registers or from FSM state only; there SHALL be no combinational path from any input to any output.

Reset
REQ-029 While aresetn=0: all registers 0; arready, awready, wready, rvalid, bvalid all 0; rdata 0; rresp and bresp 2'b00; latched AW/W cleared; both FSMs in ACCEPT.
REQ-030 arready, awready and wready SHALL first assert on the first rising edge after aresetn deasserts.
REQ-031 Reset asserted mid-transaction SHALL abort it, discard any partially latched AW or W, and commit no write.

Verification
REQ-032 AW and W together to 0x4, wdata=0xDEADBEEF, wstrb=0xF, bready=1 -> bvalid 1 cycle later with bresp=00; regs_o[1]=0xDEADBEEF.
REQ-033 W (0x000000AA, wstrb=0x1) 3 cycles before AW (0x8) -> wready drops after W; reg2 byte0=0xAA, upper bytes unchanged.
REQ-034 Read 0x4 with rready held 0 for 4 cycles -> rvalid rises 1 cycle after AR; rdata=0xDEADBEEF held stable throughout; arready=0 until the cycle after rready.
REQ-035 Write and read to 0x20 with NUM_REGS=8 -> bresp=10 and rresp=10 with rdata=0; regs_o unchanged.
REQ-036 AR to 0xC on the same edge as a write commit of 0x12345678 to 0xC (old value 0) -> rdata=0; a subsequent read returns 0x12345678.
REQ-037 aresetn pulsed low after the AW handshake but before W -> all outputs at reset values; a following W alone causes no commit and no bvalid.
